// File: rtl/proc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared constants and types for the 9-bit processor sequencer:
//               word width, opcode encodings and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int WORD_W = 9;

    localparam logic [2:0] OP_MV   = 3'd0;
    localparam logic [2:0] OP_MVI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [3:0] {
        ST_DRAIN     = 4'd0,
        ST_IDLE      = 4'd1,
        ST_FETCH     = 4'd2,
        ST_DECODE    = 4'd3,
        ST_FETCH_IMM = 4'd4,
        ST_LATCH_IMM = 4'd5,
        ST_ISSUE     = 4'd6,
        ST_EXEC      = 4'd7,
        ST_HALT      = 4'd8,
        ST_ERROR     = 4'd9
    } seq_state_t;

    // Opcode lives in the top three bits of every instruction word.
    function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: 3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_sequencer_if
// Description : Instruction-memory and processor-side bus of the sequencer.
//               master = sequencer, slave = memory + processor.
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_sequencer_if #(
    parameter int ADDR_W = 5
);
    import proc_pkg::*;

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic [WORD_W-1:0] proc_din;
    logic              proc_run;
    logic              proc_done;

    modport master (
        output mem_rd, mem_addr, proc_din, proc_run,
        input  mem_data, proc_done
    );

    modport slave (
        input  mem_rd, mem_addr, proc_din, proc_run,
        output mem_data, proc_done
    );

endinterface
`default_nettype wire

// File: rtl/proc_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : seq_watchdog
// Description : Up-counter with synchronous clear and enable, expiring at
//               TIMEOUT-1. Reset loads PRELOAD so the same counter can time a
//               shorter interval (TIMEOUT-PRELOAD cycles) straight out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
    parameter int TIMEOUT = 8,
    parameter int PRELOAD = 0
) (
    input  wire  clock,
    input  wire  resetn,
    input  wire  clear,
    input  wire  enable,
    output logic expire
);
    localparam int              CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   c_last    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   c_preload = CW'(PRELOAD);

    logic [CW-1:0] r_count;

    // Count enabled cycles; hold once expired so the flag stays stable.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count <= c_preload;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : proc_sequencer
// Description : Program sequencer for the 9-bit simple processor. Fetches
//               words from a 1-cycle synchronous memory, issues each with a
//               single run pulse, supplies mvi immediates in processor T1,
//               counts retired instructions and stops on halt, stop or
//               watchdog timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 8,
    parameter int DRAIN   = 3
) (
    input  wire               clock,
    input  wire               resetn,
    input  wire               start,
    input  wire [ADDR_W-1:0]  start_addr,
    input  wire               stop,
    proc_sequencer_if.master  bus,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [15:0]       instr_count
);
    seq_state_t         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [WORD_W-1:0]  r_instr;
    logic [WORD_W-1:0]  r_imm;
    logic               r_busy;
    logic               r_halted;
    logic               r_error;
    logic [15:0]        r_count;

    logic [2:0]         w_op;
    logic [2:0]         w_mem_op;
    logic               w_wd_clear;
    logic               w_wd_enable;
    logic               w_wd_expire;

    assign w_op     = opcode_of(r_instr);
    assign w_mem_op = opcode_of(bus.mem_data);

    // One counter serves both the post-reset drain (preloaded so it expires
    // after DRAIN cycles) and the EXEC watchdog (cleared in ISSUE).
    assign w_wd_clear  = (r_state == ST_ISSUE);
    assign w_wd_enable = (r_state == ST_DRAIN) || (r_state == ST_EXEC);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT),
        .PRELOAD (TIMEOUT - DRAIN)
    ) u_watchdog (
        .clock  (clock),
        .resetn (resetn),
        .clear  (w_wd_clear),
        .enable (w_wd_enable),
        .expire (w_wd_expire)
    );

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_DRAIN;
            r_pc     <= '0;
            r_instr  <= '0;
            r_imm    <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_DRAIN: begin
                    if (w_wd_expire) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE, ST_HALT, ST_ERROR: begin
                    if (start) begin
                        r_pc     <= start_addr;
                        r_halted <= 1'b0;
                        r_error  <= 1'b0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_instr <= bus.mem_data;
                    r_pc    <= r_pc + 1'b1;
                    if (w_mem_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_HALT;
                    end else if (w_mem_op == OP_MVI) begin
                        r_state <= ST_FETCH_IMM;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_FETCH_IMM: begin
                    r_state <= ST_LATCH_IMM;
                end
                ST_LATCH_IMM: begin
                    r_imm   <= bus.mem_data;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // done takes priority over a simultaneous watchdog expiry
                    if (bus.proc_done) begin
                        if (r_count != 16'hFFFF) begin
                            r_count <= r_count + 16'd1;
                        end
                        if (stop) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end else if (w_wd_expire) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_ERROR;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_DRAIN;
                end
            endcase
        end
    end

    // Memory and processor strobes decode directly from the state register.
    assign bus.mem_rd   = (r_state == ST_FETCH) || (r_state == ST_FETCH_IMM);
    assign bus.mem_addr = r_pc;
    assign bus.proc_run = (r_state == ST_ISSUE);
    assign bus.proc_din = (r_state == ST_ISSUE)                       ? r_instr :
                          ((r_state == ST_EXEC) && (w_op == OP_MVI))  ? r_imm   :
                                                                        '0;

    assign busy        = r_busy;
    assign halted      = r_halted;
    assign error       = r_error;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_sequencer
// Description : Directed self-checking bench for proc_sequencer with a small
//               behavioural processor model and a done stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_sequencer;
    import proc_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 8;
    localparam int DRAIN   = 3;

    logic              clock      = 1'b0;
    logic              resetn     = 1'b0;
    logic              start      = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              stop       = 1'b0;
    logic              busy;
    logic              halted;
    logic              error;
    logic [15:0]       instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    proc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    proc_sequencer #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .DRAIN   (DRAIN)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .start_addr  (start_addr),
        .stop        (stop),
        .bus         (bus),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    // Synchronous instruction memory, one-cycle read latency.
    logic [8:0] mem [32];
    always @(posedge clock) begin
        if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    // Behavioural processor: mv/mvi finish in T1, add/sub in T3.
    logic       stub_mode = 1'b0;
    logic       stub_done = 1'b0;
    logic [8:0] rf [8] = '{default: 9'd0};
    logic [8:0] p_ir = '0;
    logic [8:0] p_a  = '0;
    logic [8:0] p_g  = '0;
    logic [1:0] p_t  = '0;
    logic [2:0] p_op, p_x, p_y;
    logic       real_done;

    assign p_op = p_ir[8:6];
    assign p_x  = p_ir[5:3];
    assign p_y  = p_ir[2:0];
    assign real_done = ((p_t == 2'd1) && (p_op == OP_MV  || p_op == OP_MVI)) ||
                       ((p_t == 2'd3) && (p_op == OP_ADD || p_op == OP_SUB));
    assign bus.proc_done = stub_mode ? stub_done : real_done;

    always @(posedge clock) begin
        case (p_t)
            2'd0: if (bus.proc_run && !stub_mode) begin
                p_ir <= bus.proc_din;
                p_t  <= 2'd1;
            end
            2'd1: begin
                if (p_op == OP_MV)       rf[p_x] <= rf[p_y];
                else if (p_op == OP_MVI) rf[p_x] <= bus.proc_din;
                else                     p_a     <= rf[p_x];
                p_t <= (p_op == OP_ADD || p_op == OP_SUB) ? 2'd2 : 2'd0;
            end
            2'd2: begin
                p_g <= (p_op == OP_SUB) ? p_a - rf[p_y] : p_a + rf[p_y];
                p_t <= 2'd3;
            end
            default: begin
                rf[p_x] <= p_g;
                p_t     <= 2'd0;
            end
        endcase
    end

    int run_pulses = 0;
    always @(posedge clock) begin
        if (bus.proc_run) run_pulses <= run_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Present start for one sampling edge; returns in the first FETCH cycle.
    task automatic do_start(input logic [ADDR_W-1:0] addr);
        start      = 1'b1;
        start_addr = addr;
        step(1);
        start      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 32; i++) mem[i] = 9'h000;

        // ---------------- reset state ----------------
        step(2);
        check("rst_flags", {busy, halted, error, bus.mem_rd, bus.proc_run}, 5'b0);
        check("rst_count", instr_count, 16'd0);
        check("rst_addr",  bus.mem_addr, 5'd0);
        check("rst_din",   bus.proc_din, 9'd0);
        resetn = 1'b1;
        step(3);

        // ---------------- mvi/mvi/add/halt program ----------------
        mem[0] = 9'h040; mem[1] = 9'h005; mem[2] = 9'h048;
        mem[3] = 9'h003; mem[4] = 9'h081; mem[5] = 9'h1C0;
        base = run_pulses;
        do_start(5'd0);
        check("p1_fetch", {busy, bus.mem_rd}, 2'b11);
        check("p1_addr0", bus.mem_addr, 5'd0);
        step(4);
        check("p1_run",     bus.proc_run, 1'b1);
        check("p1_din_op",  bus.proc_din, 9'h040);
        step(1);
        check("p1_din_imm", bus.proc_din, 9'h005);
        check("p1_run_low", bus.proc_run, 1'b0);
        step(10);
        check("p1_add_din0", bus.proc_din, 9'h000);
        step(4);
        check("p1_not_yet_halt", {halted, busy}, 2'b01);
        step(1);
        check("p1_halted",  {halted, busy}, 2'b10);
        check("p1_count",   instr_count, 16'd3);
        check("p1_rg",      p_g, 9'd8);
        check("p1_r0",      rf[0], 9'd8);
        check("p1_pulses",  run_pulses - base, 32'd3);
        check("p1_pc",      bus.mem_addr, 5'd6);

        // ---------------- PC wrap across mvi immediate ----------------
        mem[31] = 9'h040; mem[0] = 9'h00A; mem[1] = 9'h1C0;
        do_start(5'd31);
        check("w_halt_clr", halted, 1'b0);
        check("w_addr31",   bus.mem_addr, 5'd31);
        step(2);
        check("w_imm_addr", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'd0});
        step(3);
        check("w_imm_din",  bus.proc_din, 9'h00A);
        step(1);
        check("w_next",     {bus.mem_rd, bus.mem_addr}, {1'b1, 5'd1});
        step(2);
        check("w_r0",       rf[0], 9'd10);
        check("w_done",     {halted, instr_count}, {1'b1, 16'd1});

        // ---------------- watchdog timeout ----------------
        stub_mode = 1'b1;
        stub_done = 1'b0;
        mem[2] = 9'h081; mem[3] = 9'h1C0;
        do_start(5'd2);
        step(2);
        check("wd_run",      bus.proc_run, 1'b1);
        step(8);
        check("wd_pre",      {error, busy}, 2'b01);
        step(1);
        check("wd_error",    {error, busy, halted}, 3'b100);
        check("wd_count",    instr_count, 16'd0);

        // ---------------- done / timeout tie ----------------
        do_start(5'd2);
        check("tie_err_clr", error, 1'b0);
        step(10);
        stub_done = 1'b1;
        step(1);
        stub_done = 1'b0;
        check("tie_retire",  {error, bus.mem_rd, bus.mem_addr}, {1'b0, 1'b1, 5'd3});
        check("tie_count",   instr_count, 16'd1);
        step(2);
        check("tie_halt",    {halted, error}, 2'b10);
        stub_mode = 1'b0;

        // ---------------- stop and ignored start ----------------
        mem[8] = 9'h081; mem[9] = 9'h1C0;
        base = run_pulses;
        do_start(5'd8);
        start      = 1'b1;
        start_addr = 5'd20;
        step(1);
        start      = 1'b0;
        check("ign_start_pc", bus.mem_addr, 5'd8);
        step(2);
        stop = 1'b1;
        step(3);
        check("stop_idle",   {busy, halted, error}, 3'b000);
        check("stop_count",  instr_count, 16'd1);
        check("stop_pc",     bus.mem_addr, 5'd9);
        check("stop_r0",     rf[0], 9'd13);
        check("stop_pulses", run_pulses - base, 32'd1);
        step(1);
        check("stop_in_idle", {busy, bus.mem_rd}, 2'b00);
        stop = 1'b0;

        // ---------------- reset mid-instruction ----------------
        do_start(5'd8);
        step(3);
        check("mr_pre", {busy, bus.mem_addr}, {1'b1, 5'd9});
        #2;
        resetn = 1'b0;
        #1;
        check("mr_async_flags", {busy, halted, error, bus.mem_rd, bus.proc_run}, 5'b0);
        check("mr_async_addr",  bus.mem_addr, 5'd0);
        check("mr_async_din",   bus.proc_din, 9'd0);
        start      = 1'b1;
        start_addr = 5'd8;
        step(1);
        resetn = 1'b1;
        for (int i = 1; i <= DRAIN; i++) begin
            step(1);
            check($sformatf("mr_drain%0d", i), busy, 1'b0);
        end
        step(1);
        start = 1'b0;
        check("mr_accept", {busy, bus.mem_addr}, {1'b1, 5'd8});
        step(7);
        check("mr_pre_halt", halted, 1'b0);
        step(1);
        check("mr_halt",  {halted, instr_count}, {1'b1, 16'd1});
        check("mr_r0",    rf[0], 9'd19);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_sequencer.md
# proc_sequencer

Program sequencer for the 9-bit simple processor. It fetches instruction words from a synchronous instruction memory and presents each to the processor's `DIN` with a one-cycle `run` pulse. For `mvi` it supplies the immediate word in the following cycle, waits for `done`, counts retired instructions, and stops on a halt opcode, a `stop` request or a watchdog timeout.

## Interface
- `ADDR_W`, 5: instruction memory address width; PC wraps modulo 2^ADDR_W.
- `TIMEOUT`, 8: max cycles in EXEC without `done` before error.
- `DRAIN`, 3: cycles `run` is held low after reset, before `start` is accepted.
---
- `clock`  in  1  sole clock; all state updates on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution at `start_addr`; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first instruction address.
- `stop`  in  1  level; finish current instruction, then return to IDLE.
- `mem_rd`  out  1  read strobe; data valid on `mem_data` the next cycle.
- `mem_addr`  out  ADDR_W  current PC (registered).
- `mem_data`  in  9  instruction or immediate word.
- `proc_din`  out  9  drives processor `DIN`.
- `proc_run`  out  1  drives processor `run`.
- `proc_done`  in  1  processor `done`, combinational from processor.
- `busy`  out  1  high in every state except DRAIN/IDLE/HALT/ERROR.
- `halted`  out  1  sticky; set on halt opcode; cleared by accepted `start`.
- `error`  out  1  sticky; set on watchdog timeout; cleared by accepted `start`.
- `instr_count`  out  16  instructions retired since last accepted `start`; saturates at 0xFFFF.

## Operation
- Reset: state DRAIN, PC=0, all outputs 0, `proc_din`=0, counters 0.
- Opcode = word[8:6]. 0=mv, 1=mvi, 2=add, 3=sub, 7=halt (never issued). Opcodes 4–6 are issued and retire when `proc_done` is seen; otherwise they time out.
- States and transitions:
  - **DRAIN**: count DRAIN cycles with `run`=0 so the processor returns to T0, then go to IDLE.
  - **IDLE**: on `start`: PC←`start_addr`, clear `halted`/`error`/`instr_count`, then go to FETCH.
  - **FETCH**: `mem_rd`=1, then go to DECODE.
  - **DECODE**: instr←`mem_data`, PC←PC+1.
    - op=7: go to HALT.
    - op=1: go to FETCH_IMM.
    - Otherwise: go to ISSUE.
  - **FETCH_IMM**: `mem_rd`=1, then go to LATCH_IMM.
  - **LATCH_IMM**: imm←`mem_data`, PC←PC+1, then go to ISSUE.
  - **ISSUE**: `proc_din`=instr, `proc_run`=1, watchdog←0, then go to EXEC.
  - **EXEC**: `proc_din`=imm if op=1, else 0; `proc_run`=0.
    - On `proc_done`: `instr_count`+1; go to IDLE if `stop`, else FETCH.
    - Otherwise, when watchdog reaches TIMEOUT-1: set `error`, go to ERROR.
  - **HALT / ERROR**: idle, `busy`=0; accept `start` exactly as in IDLE.
- `proc_din`=0 and `proc_run`=0 in every state not listed above as driving them.
- `start` while `busy` is ignored. `stop` outside EXEC takes effect at the next EXEC retirement; `stop` in IDLE has no effect.
- PC increments wrap from 2^ADDR_W−1 to 0, including between an mvi opcode and its immediate.
- Simultaneous `proc_done` and watchdog expiry: `done` wins (retire, no error).
- `resetn` low mid-instruction: immediate return to DRAIN. The DRAIN delay guarantees the processor reaches T0 before the next ISSUE.

## Timing
- Cycles per instruction, FETCH to next FETCH:
  - mv: 4.
  - mvi: 6.
  - add/sub: 6 (done arrives in the 3rd EXEC cycle).
- `proc_run` is asserted for exactly 1 cycle per instruction.
- The mvi immediate is on `proc_din` in the cycle immediately after the `run` cycle (processor T1).
- Memory read latency is fixed at 1 cycle; no backpressure.
- Outputs are registered, except `proc_din`/`proc_run`/`mem_rd`, which decode from the registered state.

## Structure
- Package `proc_pkg`: opcode constants (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_HALT`), state enum, word width 9.
- Sub-module `seq_watchdog`: loadable counter with clear/enable and an expire flag, parameterised by TIMEOUT. It is also used to implement DRAIN.

## Test plan
- **mvi/add program with a real processor attached.** Reset, then `start`, `start_addr`=0, with memory {0x040, 0x005, 0x048, 0x003, 0x081, 0x1C0}.
  - `proc_din` shows 0x040 then 0x005 on consecutive cycles.
  - RG=8, `instr_count`=3, `halted`=1, `busy`=0.
  - Total of 6+6+6+2 cycles from `start`.
- **Watchdog.** Stub processor that never asserts done; word 0x081 → `error`=1 exactly TIMEOUT cycles after ISSUE; `instr_count`=0.
- **PC wrap.** `start_addr`=31 with mvi 0x040 at address 31 and immediate 0x00A at address 0 → R0=10, next fetch at address 1.
- **Stop and ignored start.** Assert `stop` during an add's EXEC → the add retires, then IDLE with `halted`=0; a `start` pulse during `busy` changes nothing.
- **Reset mid-instruction.** Drop `resetn` in EXEC → all outputs 0 asynchronously; `start` is ignored for 3 cycles after release, then accepted.
- **Done/timeout tie.** Stub asserts done on the cycle the watchdog expires → retire, `error`=0.
